// File: rtl/load_align_unit.sv
// load_align_unit: load-path stage feeding the byte/halfword extender.
// Accepts one load request, issues a word-aligned read, waits for mem_ack,
// right-justifies the addressed lane and hands it to the extend stage over
// a valid/ready handshake. At most one load is outstanding.
// Optional build macro LOAD_ALIGN_FAULT_EN: misaligned halfword/word
// requests raise an err pulse instead of silently dropping low address bits.
module load_align_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ext_valid,
    input  logic        ext_ready,
    output logic [31:0] ext_num,
    output logic        ext_mode,
    output logic        ext_sign,
    output logic        ext_bypass,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [1:0]  state;
    logic [1:0]  cap_lo;
    logic [1:0]  cap_size;
    logic        cap_sign;
    logic [15:0] wait_cnt;
    logic [31:0] lane;
    logic        misaligned;
    logic        req_fault;

    // Select and right-justify the addressed lane of the returning word.
    always_comb begin
        lane = '0;
        case (cap_size)
            SZ_BYTE: lane = {24'b0, mem_rdata[{cap_lo, 3'b000} +: 8]};
            SZ_HALF: lane = cap_lo[1] ? {16'b0, mem_rdata[31:16]}
                                      : {16'b0, mem_rdata[15:0]};
            default: lane = mem_rdata;
        endcase
    end

    // Decide whether an incoming request is rejected without a memory access.
    always_comb begin
`ifdef LOAD_ALIGN_FAULT_EN
        misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        req_fault = (req_size == SZ_RSVD) || misaligned;
    end

    // Control FSM and registered outputs; err is a pulse that lasts the ERR state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            ext_valid  <= 1'b0;
            ext_num    <= '0;
            ext_mode   <= 1'b0;
            ext_sign   <= 1'b0;
            ext_bypass <= 1'b0;
            err        <= 1'b0;
            wait_cnt   <= '0;
            cap_lo     <= '0;
            cap_size   <= '0;
            cap_sign   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        cap_lo    <= req_addr[1:0];
                        cap_size  <= req_size;
                        cap_sign  <= req_sign;
                        req_ready <= 1'b0;
                        if (req_fault) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            state     <= S_REQ;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_rd_en  <= 1'b0;
                        wait_cnt   <= '0;
                        ext_valid  <= 1'b1;
                        ext_num    <= lane;
                        ext_mode   <= (cap_size == SZ_HALF);
                        ext_sign   <= cap_sign && (cap_size != SZ_WORD);
                        ext_bypass <= (cap_size == SZ_WORD);
                        state      <= S_OUT;
                    end else if ((TIMEOUT_CYCLES != 0) &&
                                 (({1'b0, wait_cnt} + 17'd1) == TIMEOUT_LIMIT)) begin
                        mem_rd_en <= 1'b0;
                        wait_cnt  <= '0;
                        err       <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_OUT: begin
                    if (ext_ready) begin
                        ext_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: table-driven bench for load_align_unit with a
// scoreboard of expected extend-stage transfers and err pulses.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_sign;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ext_valid;
    logic        ext_ready;
    logic [31:0] ext_num;
    logic        ext_mode;
    logic        ext_sign;
    logic        ext_bypass;
    logic        err;

    load_align_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .ext_num   (ext_num),
        .ext_mode  (ext_mode),
        .ext_sign  (ext_sign),
        .ext_bypass(ext_bypass),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] rdata;
        int unsigned delay;
        int unsigned hold;
        logic [31:0] exp_num;
        logic        exp_mode;
        logic        exp_sign;
        logic        exp_byp;
        logic        exp_err;
        logic [31:0] exp_maddr;
    } vec_t;

    typedef struct {
        logic [31:0] num;
        logic        mode;
        logic        sign;
        logic        byp;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        tbl[11];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] size, input logic sign,
                                input logic [31:0] rdata, input int unsigned delay, input int unsigned hold,
                                input logic [31:0] exp_num, input logic exp_mode, input logic exp_sign,
                                input logic exp_byp, input logic exp_err, input logic [31:0] exp_maddr);
        vec_t v;
        v.addr = addr; v.size = size; v.sign = sign; v.rdata = rdata;
        v.delay = delay; v.hold = hold; v.exp_num = exp_num; v.exp_mode = exp_mode;
        v.exp_sign = exp_sign; v.exp_byp = exp_byp; v.exp_err = exp_err; v.exp_maddr = exp_maddr;
        return v;
    endfunction

    // Scoreboard: every err pulse or accepted extend transfer consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && (err || (ext_valid && ext_ready))) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: got err=%b ext_valid=%b expected no output", err, ext_valid);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_err", 32'(err), 32'(mon_e.err));
                if (mon_e.err) begin
                    chk("sb_no_valid_on_err", 32'(ext_valid), 32'd0);
                end else begin
                    chk("sb_num", ext_num, mon_e.num);
                    chk("sb_mode", 32'(ext_mode), 32'(mon_e.mode));
                    chk("sb_sign", 32'(ext_sign), 32'(mon_e.sign));
                    chk("sb_bypass", 32'(ext_bypass), 32'(mon_e.byp));
                end
            end
        end
    end

    task automatic do_load(input vec_t v);
        int unsigned n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        e.num = v.exp_num; e.mode = v.exp_mode; e.sign = v.exp_sign;
        e.byp = v.exp_byp; e.err = v.exp_err;
        sbq.push_back(e);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_size  = v.size;
        req_sign  = v.sign;
        ext_ready = (v.hold == 0);
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (v.exp_err) begin
            chk("no_rd_en_on_err", 32'(mem_rd_en), 32'd0);
            chk("err_pulse", 32'(err), 32'd1);
            tick();
            chk("err_one_cycle", 32'(err), 32'd0);
            chk("idle_after_err", 32'(req_ready), 32'd1);
        end else begin
            chk("rd_en_issue", 32'(mem_rd_en), 32'd1);
            chk("mem_addr", mem_addr, v.exp_maddr);
            for (int unsigned i = 0; i < v.delay; i++) tick();
            chk("rd_en_held", 32'(mem_rd_en), 32'd1);
            chk("mem_addr_stable", mem_addr, v.exp_maddr);
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            chk("rd_en_drop", 32'(mem_rd_en), 32'd0);
            chk("ext_valid_latency", 32'(ext_valid), 32'd1);
            for (int unsigned i = 0; i < v.hold; i++) begin
                chk("hold_valid", 32'(ext_valid), 32'd1);
                chk("hold_num", ext_num, v.exp_num);
                chk("hold_bypass", 32'(ext_bypass), 32'(v.exp_byp));
                chk("hold_req_ready", 32'(req_ready), 32'd0);
                tick();
            end
            ext_ready = 1'b1;
            tick();
            chk("ext_valid_drop", 32'(ext_valid), 32'd0);
            chk("req_ready_back", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        tbl[0]  = mk(32'h1003, 2'b00, 1'b1, 32'h80FF1234, 0, 0, 32'h00000080, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000);
        tbl[1]  = mk(32'h2002, 2'b01, 1'b0, 32'hBEEF1234, 0, 0, 32'h0000BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000);
        tbl[2]  = mk(32'h3000, 2'b10, 1'b1, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3000);
        tbl[3]  = mk(32'h0001, 2'b00, 1'b0, 32'hA1B2C3D4, 2, 0, 32'h000000C3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000);
        tbl[4]  = mk(32'h0000, 2'b00, 1'b1, 32'hA1B2C3D4, 1, 0, 32'h000000D4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000);
        tbl[5]  = mk(32'h8002, 2'b00, 1'b0, 32'hA1B2C3D4, 0, 1, 32'h000000B2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000);
        tbl[6]  = mk(32'h9000, 2'b01, 1'b1, 32'hA1B2C3D4, 0, 0, 32'h0000C3D4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h9000);
        tbl[7]  = mk(32'h4000, 2'b11, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
`ifdef LOAD_ALIGN_FAULT_EN
        tbl[8]  = mk(32'h0001, 2'b01, 1'b1, 32'h12345678, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tbl[9]  = mk(32'h5002, 2'b10, 1'b0, 32'h01234567, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
`else
        tbl[8]  = mk(32'h0001, 2'b01, 1'b1, 32'h12345678, 0, 0, 32'h00005678, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000);
        tbl[9]  = mk(32'h5002, 2'b10, 1'b0, 32'h01234567, 0, 0, 32'h01234567, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5000);
`endif
        tbl[10] = mk(32'hFFFF0007, 2'b00, 1'b0, 32'hFFEEDDCC, 3, 0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF0004);

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_sign = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; ext_ready = 1'b1;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ext_valid", 32'(ext_valid), 32'd0);
        chk("rst_ext_num", ext_num, 32'd0);
        chk("rst_ctrl", {29'd0, ext_mode, ext_sign, ext_bypass}, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        foreach (tbl[i]) do_load(tbl[i]);

        // Timeout: no acknowledge ever arrives.
        sbq.push_back('{num: 32'd0, mode: 1'b0, sign: 1'b0, byp: 1'b0, err: 1'b1});
        req_valid = 1'b1; req_addr = 32'h7000; req_size = 2'b00; req_sign = 1'b0;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (mem_rd_en && n < 12) begin
            n++;
            tick();
        end
        chk("timeout_rd_cycles", n, 32'd4);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_no_valid", 32'(ext_valid), 32'd0);
        tick();
        chk("timeout_err_clear", 32'(err), 32'd0);
        chk("timeout_idle", 32'(req_ready), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_no_valid", 32'(ext_valid), 32'd0);
        chk("late_ack_no_rd", 32'(mem_rd_en), 32'd0);

        // Reset in the middle of a read, then a stray acknowledge in IDLE.
        req_valid = 1'b1; req_addr = 32'h6004; req_size = 2'b10; req_sign = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("midreq_rd_en", 32'(mem_rd_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_ext_valid", 32'(ext_valid), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_valid", 32'(ext_valid), 32'd0);
            chk("post_rst_no_rd", 32'(mem_rd_en), 32'd0);
            tick();
        end
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        chk("sb_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
